// File: rtl/zhang_cnn_pkg.sv
// Shared widths, limits and FSM encoding for the CNN accumulate/requantise slice.
package zhang_cnn_pkg;
  localparam int PROD_W  = 16;
  localparam int ACT_W   = 9;
  localparam int SHIFT_W = 4;
  localparam int ACT_MAX = 511;

  typedef enum logic {
    S_ACC = 1'b0,
    S_OUT = 1'b1
  } state_t;
endpackage

// File: rtl/zhang_cnn_requant.sv
// Combinational requantiser: round-half-up, arithmetic right shift, clamp to 9-bit unsigned.
module zhang_cnn_requant
  import zhang_cnn_pkg::*;
#(
  parameter int ACC_WIDTH = 32
) (
  input  logic signed [ACC_WIDTH-1:0] sum,
  input  logic        [SHIFT_W-1:0]   shift,
  output logic        [ACT_W-1:0]     data,
  output logic                        sat
);
  localparam logic signed [ACC_WIDTH:0] MAXV = (ACC_WIDTH+1)'(ACT_MAX);

  logic signed [ACC_WIDTH:0] sum_ext;
  logic signed [ACC_WIDTH:0] rnd;
  logic signed [ACC_WIDTH:0] r;

  always_comb begin
    // One extra bit so adding the rounding constant can never wrap.
    sum_ext = {sum[ACC_WIDTH-1], sum};
    rnd     = ((ACC_WIDTH+1)'(1) << shift) >> 1;
    r       = (sum_ext + rnd) >>> shift;
    sat     = (r < 0) || (r > MAXV);
    if (r < 0) begin
      data = '0;
    end else if (r > MAXV) begin
      data = ACT_W'(ACT_MAX);
    end else begin
      data = r[ACT_W-1:0];
    end
  end
endmodule

// File: rtl/zhang_cnn_acc_requant.sv
// Window accumulator: sums ACC_LEN products plus bias, then presents one requantised activation.
module zhang_cnn_acc_requant
  import zhang_cnn_pkg::*;
#(
  parameter int ACC_LEN   = 9,
  parameter int ACC_WIDTH = 32
) (
  input  logic                      ap_clk,
  input  logic                      ap_rst,
  input  logic signed [PROD_W-1:0]  in_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [PROD_W-1:0]  bias,
  input  logic        [SHIFT_W-1:0] shift,
  output logic        [ACT_W-1:0]   out_data,
  output logic                      out_sat,
  output logic                      out_valid,
  input  logic                      out_ready
);
  localparam int CNT_W = (ACC_LEN > 1) ? $clog2(ACC_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACC_LEN - 1);

  state_t                       state_reg;
  logic        [CNT_W-1:0]      cnt_reg;
  logic signed [ACC_WIDTH-1:0]  acc_reg;
  logic signed [ACC_WIDTH-1:0]  acc_next;
  logic        [SHIFT_W-1:0]    shift_reg;
  logic        [SHIFT_W-1:0]    shift_next;
  logic        [ACT_W-1:0]      out_data_reg;
  logic                         out_sat_reg;
  logic        [ACT_W-1:0]      rq_data;
  logic                         rq_sat;
  logic                         beat;
  logic                         first_beat;
  logic                         last_beat;

  assign in_ready   = (state_reg == S_ACC);
  assign out_valid  = (state_reg == S_OUT);
  assign out_data   = out_data_reg;
  assign out_sat    = out_sat_reg;
  assign beat       = in_valid && in_ready;
  assign first_beat = (cnt_reg == '0);
  assign last_beat  = (cnt_reg == CNT_LAST);

  // On the first beat bias/shift come straight from the ports so ACC_LEN=1 works.
  always_comb begin
    acc_next   = acc_reg + {{(ACC_WIDTH-PROD_W){in_data[PROD_W-1]}}, in_data};
    shift_next = shift_reg;
    if (first_beat) begin
      acc_next   = {{(ACC_WIDTH-PROD_W){bias[PROD_W-1]}}, bias}
                 + {{(ACC_WIDTH-PROD_W){in_data[PROD_W-1]}}, in_data};
      shift_next = shift;
    end
  end

  zhang_cnn_requant #(
    .ACC_WIDTH(ACC_WIDTH)
  ) u_requant (
    .sum  (acc_next),
    .shift(shift_next),
    .data (rq_data),
    .sat  (rq_sat)
  );

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_reg    <= S_ACC;
      cnt_reg      <= '0;
      acc_reg      <= '0;
      shift_reg    <= '0;
      out_data_reg <= '0;
      out_sat_reg  <= 1'b0;
    end else begin
      case (state_reg)
        S_ACC: begin
          if (beat) begin
            acc_reg   <= acc_next;
            shift_reg <= shift_next;
            if (last_beat) begin
              cnt_reg      <= '0;
              out_data_reg <= rq_data;
              out_sat_reg  <= rq_sat;
              state_reg    <= S_OUT;
            end else begin
              cnt_reg <= cnt_reg + 1'b1;
            end
          end
        end
        S_OUT: begin
          if (out_ready) begin
            state_reg <= S_ACC;
          end
        end
        default: state_reg <= S_ACC;
      endcase
    end
  end
endmodule

// File: tb/tb_zhang_cnn_acc_requant.sv
// Directed bench: window vectors with hand-computed results, plus reset, backpressure and ACC_LEN=1 sequences.
module tb_zhang_cnn_acc_requant;
  localparam int N = 9;

  logic               ap_clk = 1'b0;
  logic               ap_rst = 1'b1;
  logic signed [15:0] in_data = '0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic signed [15:0] bias = '0;
  logic        [3:0]  shift = '0;
  logic        [8:0]  out_data;
  logic               out_sat;
  logic               out_valid;
  logic               out_ready = 1'b1;

  logic signed [15:0] d1_in_data = '0;
  logic               d1_in_valid = 1'b0;
  logic               d1_in_ready;
  logic signed [15:0] d1_bias = '0;
  logic        [3:0]  d1_shift = '0;
  logic        [8:0]  d1_out_data;
  logic               d1_out_sat;
  logic               d1_out_valid;
  logic               d1_out_ready = 1'b1;

  int checks = 0;
  int failures = 0;

  always #5 ap_clk = ~ap_clk;

  zhang_cnn_acc_requant #(.ACC_LEN(N), .ACC_WIDTH(32)) dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .bias(bias), .shift(shift),
    .out_data(out_data), .out_sat(out_sat), .out_valid(out_valid), .out_ready(out_ready)
  );

  zhang_cnn_acc_requant #(.ACC_LEN(1), .ACC_WIDTH(32)) dut1 (
    .ap_clk(ap_clk), .ap_rst(ap_rst),
    .in_data(d1_in_data), .in_valid(d1_in_valid), .in_ready(d1_in_ready),
    .bias(d1_bias), .shift(d1_shift),
    .out_data(d1_out_data), .out_sat(d1_out_sat), .out_valid(d1_out_valid), .out_ready(d1_out_ready)
  );

  typedef struct {
    string name;
    int    first_v;
    int    rest_v;
    int    bias_v;
    int    shift_v;
    int    exp_d;
    int    exp_s;
    int    stall;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  // Feeds one full window back-to-back; later beats carry junk bias/shift that must be ignored.
  task automatic run_window(input vec_t v);
    out_ready = (v.stall == 0);
    for (int i = 0; i < N; i++) begin
      in_valid = 1'b1;
      in_data  = 16'((i == 0) ? v.first_v : v.rest_v);
      bias     = (i == 0) ? 16'(v.bias_v) : 16'sh7abc;
      shift    = (i == 0) ? 4'(v.shift_v) : 4'd9;
      tick();
      if (i == N - 2) chk({v.name, "_valid_early"}, int'(out_valid), 0);
    end
    in_valid = 1'b0;
    chk({v.name, "_valid"}, int'(out_valid), 1);
    chk({v.name, "_data"}, int'(out_data), v.exp_d);
    chk({v.name, "_sat"}, int'(out_sat), v.exp_s);
    chk({v.name, "_in_ready_out"}, int'(in_ready), 0);
    for (int k = 0; k < v.stall; k++) begin
      in_valid = 1'b1;
      in_data  = 16'sd1000;
      tick();
      chk({v.name, "_stall_valid"}, int'(out_valid), 1);
      chk({v.name, "_stall_data"}, int'(out_data), v.exp_d);
      chk({v.name, "_stall_ready"}, int'(in_ready), 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    chk({v.name, "_after_valid"}, int'(out_valid), 0);
    chk({v.name, "_after_ready"}, int'(in_ready), 1);
    $display("window %s data=%0d sat=%0d", v.name, out_data, out_sat);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{"x100_s2",    100,    100,    0,  2, 225, 0, 0};
    vecs[1]  = '{"neg50",      -50,    -50,    0,  0,   0, 1, 0};
    vecs[2]  = '{"max_s0",     32767,  32767,  0,  0, 511, 1, 0};
    vecs[3]  = '{"round6_s2",  6,      0,      0,  2,   2, 0, 0};
    vecs[4]  = '{"bias_m7",    6,      0,     -7,  0,   0, 1, 0};
    vecs[5]  = '{"stall3",     100,    100,    0,  2, 225, 0, 3};
    vecs[6]  = '{"max_s15",    32767,  32767,  0, 15,   9, 0, 0};
    vecs[7]  = '{"negrnd_s1",  -3,     0,      0,  1,   0, 1, 0};
    vecs[8]  = '{"bias1000_s1", 0,     0,   1000,  1, 500, 0, 0};
    vecs[9]  = '{"edge511",    0,      0,    511,  0, 511, 0, 0};
    vecs[10] = '{"edge512",    0,      0,    512,  0, 511, 1, 0};
    vecs[11] = '{"mixed_s3",   -1000,  250, 100,  3, 138, 0, 0};

    ap_rst = 1'b1;
    tick();
    tick();
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_out_sat", int'(out_sat), 0);
    chk("rst1_in_ready", int'(d1_in_ready), 1);
    ap_rst = 1'b0;

    foreach (vecs[i]) run_window(vecs[i]);

    // Reset after 4 beats discards the partial sum.
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = 16'sd50; bias = 16'sd0; shift = 4'd0;
      tick();
    end
    in_valid = 1'b1;
    ap_rst   = 1'b1;
    tick();
    ap_rst   = 1'b0;
    in_valid = 1'b0;
    chk("midrst_in_ready", int'(in_ready), 1);
    chk("midrst_out_valid", int'(out_valid), 0);
    run_window('{"post_rst", 10, 10, 0, 0, 90, 0, 0});

    // Reset while an output is pending drops it.
    out_ready = 1'b0;
    for (int i = 0; i < N; i++) begin
      in_valid = 1'b1; in_data = 16'sd100; bias = 16'sd0; shift = 4'd0;
      tick();
    end
    in_valid = 1'b0;
    chk("pend_valid", int'(out_valid), 1);
    chk("pend_sat", int'(out_sat), 1);
    ap_rst = 1'b1;
    tick();
    ap_rst = 1'b0;
    out_ready = 1'b1;
    chk("outrst_valid", int'(out_valid), 0);
    chk("outrst_data", int'(out_data), 0);
    chk("outrst_sat", int'(out_sat), 0);
    run_window('{"post_outrst", 10, 10, 0, 0, 90, 0, 0});

    // ACC_LEN=1: constant stream gives a result every other cycle.
    d1_in_valid = 1'b1; d1_in_data = 16'sd7; d1_bias = 16'sd3; d1_shift = 4'd0;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("len1_valid", int'(d1_out_valid), (k % 2 == 0) ? 1 : 0);
      if (k % 2 == 0) begin
        chk("len1_data", int'(d1_out_data), 10);
        chk("len1_sat", int'(d1_out_sat), 0);
      end
      $display("len1 cycle %0d valid=%0d data=%0d", k, d1_out_valid, d1_out_data);
    end
    d1_in_valid = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/zhang_cnn_acc_requant.md
ZHANG_CNN_ACC_REQUANT -- requirements
Module: zhang_cnn_acc_requant

Interface
REQ-001 Parameter ACC_LEN, default 9: products per output window (legal 1..4096).
REQ-002 Parameter ACC_WIDTH, default 32: accumulator width.
REQ-003 ap_clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 ap_rst  in  1  reset, synchronous, active-high.
REQ-005 in_data  in  16  signed product from upstream 9ns x 16s multiplier.
REQ-006 in_valid  in  1  in_data valid.
REQ-007 in_ready  out  1  block accepts in_data this cycle.
REQ-008 bias  in  16  signed window bias; sampled on a window's first accepted beat.
REQ-009 shift  in  4  requant right-shift 0..15; sampled on a window's first accepted beat.
REQ-010 out_data  out  9  unsigned activation for next layer's 9-bit multiplier operand.
REQ-011 out_sat  out  1  out_data was clamped.
REQ-012 out_valid  out  1  out_data/out_sat valid.
REQ-013 out_ready  in  1  downstream accepts output.

Function
REQ-014 Beat accepted when in_valid && in_ready; output transferred when out_valid && out_ready.
REQ-015 FSM states S_ACC, S_OUT; reset state S_ACC.
REQ-016 S_ACC: in_ready=1, out_valid=0; S_OUT: in_ready=0, out_valid=1.
REQ-017 Beat counter cnt 0..ACC_LEN-1; increments per accepted beat; wraps to 0 on last beat.
REQ-018 First beat (cnt=0): acc <= sext(bias) + sext(in_data); shift latched.
REQ-019 Other beats: acc <= acc + sext(in_data); no overflow possible within ACC_LEN<=4096.
REQ-020 Last beat (cnt=ACC_LEN-1, including ACC_LEN=1 where first=last): final sum s = acc-next value; out_data/out_sat registered from requant(s); FSM -> S_OUT next cycle.
REQ-021 requant(s): r = (s + (shift>0 ? 2^(shift-1) : 0)) >>> shift (arithmetic); out_data = clamp(r, 0, 511); out_sat=1 iff r<0 or r>511.
REQ-022 Latency: out_valid asserted the cycle after the last beat is accepted.
REQ-023 S_OUT: out_data/out_sat held stable until transfer; on transfer FSM -> S_ACC next cycle.
REQ-024 Throughput: one window per ACC_LEN+1 cycles with no stalls.
REQ-025 in_valid low mid-window: cnt/acc hold; no timeout.
REQ-026 bias/shift changes mid-window have no effect on that window.

Reset
REQ-027 ap_rst high: FSM=S_ACC, cnt=0, acc=0, out_data=0, out_sat=0, out_valid=0, in_ready=1 from next cycle.
REQ-028 Reset mid-window or in S_OUT discards partial sum and pending output; next accepted beat starts a new window.
REQ-029 ap_rst has priority over any simultaneous handshake.

Structure
REQ-030 Shared package zhang_cnn_pkg holds PROD_W=16, ACT_W=9, SHIFT_W=4, ACT_MAX=511 and FSM state enum.
REQ-031 One combinational sub-module zhang_cnn_requant (round, shift, clamp, sat flag); FSM/counter/accumulator in top.

Verification
REQ-032 ACC_LEN=9, 9 x 100, bias 0, shift 2 -> out_data=225 (902>>2), out_sat=0, out_valid one cycle after beat 9.
REQ-033 9 x (-50), bias 0, shift 0 -> out_data=0, out_sat=1.
REQ-034 9 x 32767, bias 0, shift 0 -> out_data=511, out_sat=1.
REQ-035 Rounding: sum 6 (beats 6,0x8), bias 0, shift 2 -> out_data=2; bias -7, shift 0 -> out_data=0, out_sat=1.
REQ-036 Backpressure: out_ready low 3 cycles in S_OUT -> out_data stable, in_ready=0, in_valid beats ignored; transfer then S_ACC.
REQ-037 Reset after 4 beats, then 9 x 10, bias 0, shift 0 -> out_data=90; ACC_LEN=1 build: beat 7, bias 3 -> 10 every 2 cycles.
